// File: rtl/dec_arb_pkg.sv
// Shared types and constants for the decode-datapath arbiter.
package dec_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PARK  = 2'd2
    } state_e;

    localparam int CODE_W        = 3;   // datapath code width
    localparam int IDX_W         = 3;   // requester index width (NREQ <= 8)
    localparam int BURST_W       = 4;   // burst counter width
    localparam int GCNT_W        = 4;   // per-requester accept counter width
    localparam int DEF_NREQ      = 4;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo NREQ.
module rr_pick
    import dec_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int cand;

    // Scan candidates ptr, ptr+1, ... and keep the first requesting one.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == cand) && req[j]) begin
                    found = 1'b1;
                    idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/dec_arbiter.sv
// Round-robin burst arbiter feeding one shared decode/count datapath.
// Optional feature: define DEC_ARBITER_STATS_EN to add per-requester
// 4-bit accept counters on oGCNT.
module dec_arbiter
    import dec_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [NREQ-1:0]          iREQ,
    input  logic [CODE_W*NREQ-1:0]   iCODE,
    output logic [NREQ-1:0]          oGNT,
    output logic [IDX_W-1:0]         oOWNER,
    output logic                     oEN,
    output logic [CODE_W-1:0]        oDEC,
`ifdef DEC_ARBITER_STATS_EN
    output logic [GCNT_W*NREQ-1:0]   oGCNT,
`endif
    output logic                     oBUSY
);

    state_e              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                en_q, en_d;
    logic [CODE_W-1:0]   dec_q, dec_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;

    logic                req_own;
    logic [CODE_W-1:0]   code_own;
    logic                accept;
    logic [IDX_W-1:0]    ptr_inc;
    logic [IDX_W-1:0]    pick_ptr;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [BURST_W-1:0]  burst_inc;

    // Owner's request and code, selected without a variable-width index.
    always_comb begin
        req_own  = 1'b0;
        code_own = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                req_own  = iREQ[i];
                code_own = iCODE[CODE_W*i +: CODE_W];
            end
        end
    end

    assign accept    = (state_q == SERVE) && (|gnt_q) && req_own;
    assign ptr_inc   = (owner_q == IDX_W'(NREQ-1)) ? '0 : owner_q + IDX_W'(1);
    assign burst_inc = burst_q + BURST_W'(1);

    // In PARK the pointer moves past the owner in the same cycle, so the
    // pick must already search from owner+1.
    assign pick_ptr = (state_q == PARK) ? ptr_inc : ptr_q;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (iREQ),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        en_d    = 1'b0;
        dec_d   = dec_q;
        burst_d = burst_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = SERVE;
                    owner_d = pick_idx;
                    for (int i = 0; i < NREQ; i++) gnt_d[i] = (pick_idx == IDX_W'(i));
                end
            end
            SERVE: begin
                if (!accept) begin
                    // Owner released: give up the grant without taking a code.
                    state_d = PARK;
                    gnt_d   = '0;
                end else begin
                    en_d    = 1'b1;
                    dec_d   = code_own;
                    burst_d = burst_inc;
                    if (burst_inc == BURST_W'(MAX_BURST)) begin
                        state_d = PARK;
                        gnt_d   = '0;
                    end
                end
            end
            PARK: begin
                ptr_d   = ptr_inc;
                burst_d = '0;
                if (pick_found) begin
                    state_d = SERVE;
                    owner_d = pick_idx;
                    for (int i = 0; i < NREQ; i++) gnt_d[i] = (pick_idx == IDX_W'(i));
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any accept in flight.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            en_q    <= 1'b0;
            dec_q   <= '0;
            burst_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            en_q    <= en_d;
            dec_q   <= dec_d;
            burst_q <= burst_d;
            ptr_q   <= ptr_d;
        end
    end

    assign oGNT   = gnt_q;
    assign oOWNER = owner_q;
    assign oEN    = en_q;
    assign oDEC   = dec_q;
    assign oBUSY  = (state_q != IDLE);

`ifdef DEC_ARBITER_STATS_EN
    logic [NREQ-1:0][GCNT_W-1:0] gcnt_q, gcnt_d;

    // Count accepts per requester; counters wrap naturally.
    always_comb begin
        gcnt_d = gcnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (accept && (owner_q == IDX_W'(i))) gcnt_d[i] = gcnt_q[i] + GCNT_W'(1);
        end
    end

    // Accept counter registers.
    always_ff @(posedge iCLK) begin
        if (iRST) gcnt_q <= '0;
        else      gcnt_q <= gcnt_d;
    end

    assign oGCNT = gcnt_q;
`endif

endmodule

// File: tb/tb_dec_arbiter.sv
// Directed bench for dec_arbiter (NREQ=4, MAX_BURST=4).
module tb_dec_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [3:0]  iREQ;
    logic [11:0] iCODE;
    logic [3:0]  oGNT;
    logic [2:0]  oOWNER;
    logic        oEN;
    logic [2:0]  oDEC;
    logic        oBUSY;
`ifdef DEC_ARBITER_STATS_EN
    logic [15:0] oGCNT;
`endif

    int total = 0;
    int bad   = 0;

    dec_arbiter #(.NREQ(4), .MAX_BURST(4)) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iREQ   (iREQ),
        .iCODE  (iCODE),
        .oGNT   (oGNT),
        .oOWNER (oOWNER),
        .oEN    (oEN),
        .oDEC   (oDEC),
`ifdef DEC_ARBITER_STATS_EN
        .oGCNT  (oGCNT),
`endif
        .oBUSY  (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       en;
        logic [2:0] dec;
        logic       busy;
        logic [2:0] own;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply inputs, clock once, settle past the edge.
    task automatic step(input logic rst, input logic [3:0] req);
        iRST = rst;
        iREQ = req;
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    logic [2:0] codes[4];
    int npulse;

    initial begin
        iRST  = 1'b1;
        iREQ  = '0;
        // code0=2, code1=5, code2=7, code3=3
        iCODE = 12'o3752;
        codes[0] = 3'd2; codes[1] = 3'd5; codes[2] = 3'd7; codes[3] = 3'd3;

        //          rst   req      gnt      en    dec   busy  own
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 3'd0, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 3'd0, 1'b0, 3'd0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 1'b0, 3'd0, 1'b1, 3'd0};
        tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 3'd0};
        tbl[4]  = '{1'b0, 4'b0010, 4'b0010, 1'b0, 3'd0, 1'b1, 3'd1};
        tbl[5]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 3'd5, 1'b1, 3'd1};
        tbl[6]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 3'd5, 1'b1, 3'd1};
        tbl[7]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 3'd5, 1'b1, 3'd1};
        tbl[8]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, 3'd5, 1'b1, 3'd1};
        tbl[9]  = '{1'b0, 4'b0010, 4'b0010, 1'b0, 3'd5, 1'b1, 3'd1};
        tbl[10] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 3'd5, 1'b1, 3'd1};
        tbl[11] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 3'd5, 1'b1, 3'd1};
        tbl[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 3'd5, 1'b0, 3'd1};

        // Reset behaviour and sole-requester bursts.
        for (int r = 0; r < 13; r++) begin
            step(tbl[r].rst, tbl[r].req);
            chk($sformatf("vec%0d gnt", r),  32'(oGNT),   32'(tbl[r].gnt));
            chk($sformatf("vec%0d en", r),   32'(oEN),    32'(tbl[r].en));
            chk($sformatf("vec%0d dec", r),  32'(oDEC),   32'(tbl[r].dec));
            chk($sformatf("vec%0d busy", r), 32'(oBUSY),  32'(tbl[r].busy));
            chk($sformatf("vec%0d own", r),  32'(oOWNER), 32'(tbl[r].own));
        end

        // Round-robin with all requesting: 0,1,2,3,0, four accepts each.
        step(1'b1, 4'b0000);
        for (int b = 0; b < 5; b++) begin
            step(1'b0, 4'b1111);
            chk($sformatf("rr%0d grant", b), 32'(oGNT), 32'(oh(b % 4)));
            chk($sformatf("rr%0d owner", b), 32'(oOWNER), 32'(b % 4));
            chk($sformatf("rr%0d en0", b), 32'(oEN), 32'd0);
            for (int k = 1; k <= 4; k++) begin
                step(1'b0, 4'b1111);
                chk($sformatf("rr%0d.%0d en", b, k), 32'(oEN), 32'd1);
                chk($sformatf("rr%0d.%0d dec", b, k), 32'(oDEC), 32'(codes[b % 4]));
                chk($sformatf("rr%0d.%0d gnt", b, k), 32'(oGNT), (k < 4) ? 32'(oh(b % 4)) : 32'd0);
            end
        end

        // Early release: owner 2 drops after two accepts, 3 takes over.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        chk("early grant2", 32'(oGNT), 32'h4);
        npulse = 0;
        step(1'b0, 4'b1100); npulse += int'(oEN);
        chk("early dec", 32'(oDEC), 32'd7);
        step(1'b0, 4'b1100); npulse += int'(oEN);
        step(1'b0, 4'b1000); npulse += int'(oEN);
        chk("early park gnt", 32'(oGNT), 32'd0);
        chk("early pulses", 32'(npulse), 32'd2);
        step(1'b0, 4'b1000);
        chk("early next gnt", 32'(oGNT), 32'h8);
        chk("early next own", 32'(oOWNER), 32'd3);
        chk("early next en", 32'(oEN), 32'd0);

        // Mid-burst reset after the pointer has moved to 2.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        for (int k = 0; k < 4; k++) step(1'b0, 4'b0010);
        chk("mid park", 32'(oGNT), 32'd0);
        step(1'b0, 4'b0010);
        chk("mid regrant", 32'(oGNT), 32'h2);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        chk("mid 2nd en", 32'(oEN), 32'd1);
        step(1'b1, 4'b0010);
        chk("mid rst en", 32'(oEN), 32'd0);
        chk("mid rst gnt", 32'(oGNT), 32'd0);
        chk("mid rst busy", 32'(oBUSY), 32'd0);
        chk("mid rst dec", 32'(oDEC), 32'd0);
        step(1'b0, 4'b1111);
        chk("mid ptr0 gnt", 32'(oGNT), 32'h1);

`ifdef DEC_ARBITER_STATS_EN
        // 17 accepts by requester 0: accepts land on steps 2-5,7-10,12-15,17-20,22.
        step(1'b1, 4'b0000);
        chk("stats reset", 32'(oGCNT), 32'd0);
        npulse = 0;
        for (int c = 0; c < 22; c++) begin
            step(1'b0, 4'b0001);
            if (c > 0) npulse += int'(oEN);
        end
        step(1'b0, 4'b0000); npulse += int'(oEN);
        step(1'b0, 4'b0000);
        chk("stats pulses", 32'(npulse), 32'd17);
        chk("stats gcnt", 32'(oGCNT), 32'h0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
